// File: rtl/pipelined_regfile_scoreboard_if.sv
// Register file bundle: issue, read ports, flush and writeback.
// master = pipeline side, slave = register file side.
interface pipelined_regfile_scoreboard_if #(
  parameter int DSIZE  = 16,
  parameter int ASIZE  = 4,
  parameter int NREAD  = 2,
  parameter int WB_LAT = 3
);
  localparam int IW = $clog2(WB_LAT + 1);

  logic                   issue_valid;
  logic                   issue_wen;
  logic [ASIZE-1:0]       issue_waddr;
  logic                   issue_link;
  logic [NREAD-1:0]       ren;
  logic [NREAD*ASIZE-1:0] raddr;
  logic [NREAD*DSIZE-1:0] rdata;
  logic                   stall;
  logic                   flush;
  logic                   wb_valid;
  logic [ASIZE-1:0]       wb_waddr;
  logic [DSIZE-1:0]       wb_wdata;
  logic [IW-1:0]          inflight;
  logic                   wb_err;

  modport master (
    output issue_valid, issue_wen,
    output issue_waddr, issue_link,
    output ren, raddr, flush,
    output wb_valid, wb_waddr, wb_wdata,
    input  rdata, stall,
    input  inflight, wb_err
  );

  modport slave (
    input  issue_valid, issue_wen,
    input  issue_waddr, issue_link,
    input  ren, raddr, flush,
    input  wb_valid, wb_waddr, wb_wdata,
    output rdata, stall,
    output inflight, wb_err
  );
endinterface

// File: rtl/pipelined_regfile_scoreboard.sv
// Register file with in-flight write scoreboard, RAW stall and flush.
// Optional PRF_WB_BYPASS_EN: writeback-to-read bypass, shorter window.
module pipelined_regfile_scoreboard #(
  parameter int DSIZE       = 16,
  parameter int ASIZE       = 4,
  parameter int NREAD       = 2,
  parameter int WB_LAT      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int LINK_REG    = 15,
  parameter int ZERO_R0     = 0
) (
  input logic clk,
  input logic rst,
  pipelined_regfile_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** ASIZE;
  localparam int IW   = $clog2(WB_LAT + 1);
`ifdef PRF_WB_BYPASS_EN
  localparam int CHK = WB_LAT - 1;
  localparam bit BYP = 1'b1;
`else
  localparam int CHK = WB_LAT;
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic             v;
    logic [ASIZE-1:0] a;
  } slot_t;

  slot_t            sb [WB_LAT];
  logic [DSIZE-1:0] rf [NREG];
  logic [ASIZE-1:0] dest;
  logic             r0_dest;
  logic             accept;
  logic             new_v;
  logic             wb_we;
  logic             wb_bad;
  logic             err_q;
  logic [NREAD-1:0] hit;
  logic [IW-1:0]    cnt;

  assign dest    = bus.issue_link ?
                   ASIZE'(LINK_REG) :
                   bus.issue_waddr;
  assign r0_dest = (ZERO_R0 != 0) &&
                   (dest == '0);
  assign accept  = bus.issue_valid &
                   ~bus.stall &
                   ~bus.flush;
  assign new_v   = accept & ~r0_dest &
                   (bus.issue_wen |
                    bus.issue_link);

  assign wb_we = bus.wb_valid &
                 ~((ZERO_R0 != 0) &&
                   (bus.wb_waddr == '0));

  assign wb_bad =
    (bus.wb_valid != sb[WB_LAT-1].v) |
    (bus.wb_valid & sb[WB_LAT-1].v &
     (bus.wb_waddr != sb[WB_LAT-1].a));

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic             byp;
    logic             h;

    assign ra  = bus.raddr[i*ASIZE +: ASIZE];
    assign byp = BYP && bus.wb_valid &&
                 (bus.wb_waddr == ra);

    // Pending-write lookup over the checked slot window.
    always_comb begin
      h = 1'b0;
      for (int j = 0; j < CHK; j++)
        if (sb[j].v && sb[j].a == ra)
          h = 1'b1;
    end

    assign hit[i] = h & bus.ren[i];
    assign bus.rdata[i*DSIZE +: DSIZE] =
      ((ZERO_R0 != 0) && (ra == '0)) ? '0 :
      byp ? bus.wb_wdata : rf[ra];
  end

  // Count of live scoreboard slots.
  always_comb begin
    cnt = '0;
    for (int j = 0; j < WB_LAT; j++)
      cnt = cnt + IW'(sb[j].v);
  end

  assign bus.stall    = |hit;
  assign bus.inflight = cnt;
  assign bus.wb_err   = err_q;

  // Shift line: new issue enters, flush kills the young slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < WB_LAT; j++)
        sb[j] <= '0;
    end else begin
      sb[0] <= {new_v, dest};
      for (int j = 1; j < WB_LAT; j++) begin
        sb[j].v <= sb[j-1].v &
                   ~(bus.flush &
                     (j < FLUSH_DEPTH));
        sb[j].a <= sb[j-1].a;
      end
    end
  end

  // Register array writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        rf[k] <= '0;
    end else if (wb_we) begin
      rf[bus.wb_waddr] <= bus.wb_wdata;
    end
  end

  // Sticky writeback-vs-scoreboard error.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (wb_bad)
      err_q <= 1'b1;
  end
endmodule

// File: tb/tb_pipelined_regfile_scoreboard.sv
// Bench for pipelined_regfile_scoreboard (NREAD=3, ZERO_R0=1).
// Reference model tracks pending writes by issue cycle number.
module tb_pipelined_regfile_scoreboard;
  localparam int DS   = 16;
  localparam int AS   = 4;
  localparam int NR   = 3;
  localparam int LAT  = 3;
  localparam int FD   = 2;
  localparam int LINK = 15;
`ifdef PRF_WB_BYPASS_EN
  localparam int WIN = LAT - 1;
  localparam bit BYP = 1'b1;
`else
  localparam int WIN = LAT;
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int         c;
    logic [3:0] a;
    logic [15:0] d;
    bit         alive;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_regfile_scoreboard_if #(
    .DSIZE(DS), .ASIZE(AS),
    .NREAD(NR), .WB_LAT(LAT)
  ) bus ();

  pipelined_regfile_scoreboard #(
    .DSIZE(DS), .ASIZE(AS), .NREAD(NR),
    .WB_LAT(LAT), .FLUSH_DEPTH(FD),
    .LINK_REG(LINK), .ZERO_R0(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t        pend[$];
  logic [15:0] mreg [16];
  bit          merr;
  int          cyc;
  int          npass;
  int          ntot;
  int          nfail;

  logic        iv, iw, il, fl;
  logic [3:0]  ia;
  logic [2:0]  ren;
  logic [3:0]  ra [3];
  logic [15:0] nd;
  bit          force_dead;
  bit          man_wb;
  logic [3:0]  man_a;
  logic [15:0] man_d;

  logic        o_stall;
  logic [15:0] o_rd [3];
  logic [1:0]  o_inf;
  logic        o_err;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h",
             tag, o, e);
    end
  endtask

  task automatic tick();
    logic        wv;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [15:0] er;
    logic        es;
    logic        acc;
    logic [3:0]  dst;
    logic        dv;
    logic [3:0]  dva;
    int          ei;
    while (pend.size() > 0 &&
           pend[0].c + LAT < cyc)
      void'(pend.pop_front());
    wv = 1'b0; wa = '0; wd = '0;
    foreach (pend[i])
      if (pend[i].c + LAT == cyc &&
          (pend[i].alive || force_dead)) begin
        wv = 1'b1;
        wa = pend[i].a;
        wd = pend[i].d;
      end
    if (man_wb) begin
      wv = 1'b1; wa = man_a; wd = man_d;
    end
    bus.issue_valid = iv;
    bus.issue_wen   = iw;
    bus.issue_waddr = ia;
    bus.issue_link  = il;
    bus.ren         = ren;
    bus.raddr       = {ra[2], ra[1], ra[0]};
    bus.flush       = fl;
    bus.wb_valid    = wv;
    bus.wb_waddr    = wa;
    bus.wb_wdata    = wd;
    #2;
    es = 1'b0;
    for (int p = 0; p < NR; p++)
      if (ren[p])
        foreach (pend[i])
          if (pend[i].alive &&
              pend[i].a == ra[p] &&
              pend[i].c < cyc &&
              cyc <= pend[i].c + WIN)
            es = 1'b1;
    ei = 0;
    foreach (pend[i])
      if (pend[i].alive &&
          pend[i].c < cyc &&
          cyc <= pend[i].c + LAT)
        ei++;
    o_stall = bus.stall;
    o_inf   = bus.inflight;
    o_err   = bus.wb_err;
    for (int p = 0; p < NR; p++)
      o_rd[p] = bus.rdata[p*DS +: DS];
    if (!rst) begin
      chk("stall", 32'(o_stall), 32'(es));
      chk("inflight", 32'(o_inf), ei);
      chk("wb_err", 32'(o_err), 32'(merr));
      for (int p = 0; p < NR; p++) begin
        if (ra[p] == 4'd0)
          er = '0;
        else if (BYP && wv && wa == ra[p])
          er = wd;
        else
          er = mreg[ra[p]];
        chk($sformatf("rdata%0d", p),
            32'(o_rd[p]), 32'(er));
      end
    end
    @(posedge clk);
    if (rst) begin
      pend.delete();
      merr = 1'b0;
      foreach (mreg[i]) mreg[i] = '0;
    end else begin
      dv = 1'b0; dva = '0;
      foreach (pend[i])
        if (pend[i].alive &&
            pend[i].c + LAT == cyc) begin
          dv = 1'b1;
          dva = pend[i].a;
        end
      if (wv !== dv || (wv && wa !== dva))
        merr = 1'b1;
      if (wv && wa != 4'd0)
        mreg[wa] = wd;
      if (fl)
        foreach (pend[i])
          if (pend[i].c >= cyc - (FD - 1))
            pend[i].alive = 1'b0;
      acc = iv && !es && !fl;
      dst = il ? 4'(LINK) : ia;
      if (acc && (iw || il) && dst != 4'd0)
        pend.push_back('{cyc, dst, nd, 1'b1});
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    iv = 0; iw = 0; il = 0; fl = 0; ren = 0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [3:0] a,
                       input logic [15:0] d);
    iv = 1; iw = 1; il = 0; fl = 0; ren = 0;
    ia = a; nd = d;
    tick();
  endtask

  initial begin
    int ns;
    npass = 0; ntot = 0; nfail = 0; cyc = 0;
    iv = 0; iw = 0; il = 0; fl = 0;
    ia = 0; ren = 0; nd = 0;
    foreach (ra[i]) ra[i] = '0;
    force_dead = 0; man_wb = 0;
    man_a = 0; man_d = 0;
    merr = 0;
    foreach (mreg[i]) mreg[i] = '0;
    @(posedge clk);
    #1;
    rst = 1;
    repeat (2) tick();
    rst = 0;
    idle(1);

    issue(4'd3, 16'h1234);
    idle(4);
    ren = 3'b001; ra[0] = 4'd3;
    tick();
    chk("pre_rst_r3", 32'(o_rd[0]), 32'h1234);
    rst = 1;
    tick();
    rst = 0;
    ren = 3'b001; ra[0] = 4'd3;
    tick();
    chk("rst_r3", 32'(o_rd[0]), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_inflight", 32'(o_inf), 0);
    chk("rst_err", 32'(o_err), 0);

    issue(4'd5, 16'hBEEF);
    iv = 1; iw = 0; ren = 3'b001; ra[0] = 4'd5;
    ns = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!o_stall) break;
      ns++;
    end
    chk("raw_stalls", ns, WIN);
    chk("raw_data", 32'(o_rd[0]), 32'hBEEF);
    idle(4);

    iv = 1; iw = 0; il = 1; ia = 4'd2;
    nd = 16'h0041; ren = 0;
    tick();
    iv = 0; il = 0;
    ren = 3'b001; ra[0] = 4'd15;
    tick();
    chk("jal_r15_stall", 32'(o_stall), 1);
    ren = 3'b001; ra[0] = 4'd2;
    tick();
    chk("jal_r2_nostall", 32'(o_stall), 0);
    idle(4);
    ren = 3'b001; ra[0] = 4'd15;
    tick();
    chk("jal_r15", 32'(o_rd[0]), 32'h0041);

    idle(1);
    issue(4'd6, 16'h0606);
    issue(4'd7, 16'h0707);
    iv = 1; iw = 1; ia = 4'd8; fl = 1;
    tick();
    chk("flush_inf_before", 32'(o_inf), 2);
    iv = 0; iw = 0; fl = 0;
    force_dead = 1;
    tick();
    chk("flush_inf_after", 32'(o_inf), 1);
    tick();
    chk("flush_inf_drain", 32'(o_inf), 0);
    force_dead = 0;
    ren = 3'b001; ra[0] = 4'd6;
    tick();
    chk("flush_wb_err", 32'(o_err), 1);
    chk("flush_r6", 32'(o_rd[0]), 32'h0606);
    rst = 1;
    tick();
    rst = 0;

    issue(4'd0, 16'h5555);
    iv = 0; iw = 0;
    ren = 3'b001; ra[0] = 4'd0;
    tick();
    chk("r0_nostall", 32'(o_stall), 0);
    ren = 0; man_wb = 1;
    man_a = 4'd0; man_d = 16'hFFFF;
    tick();
    man_wb = 0;
    ren = 3'b001; ra[0] = 4'd0;
    tick();
    chk("r0_zero", 32'(o_rd[0]), 0);
    rst = 1;
    tick();
    rst = 0;

    issue(4'd1, 16'h1111);
    issue(4'd2, 16'h2222);
    idle(4);
    ren = 3'b111;
    ra[0] = 4'd1; ra[1] = 4'd2; ra[2] = 4'd1;
    tick();
    chk("port0_r1", 32'(o_rd[0]), 32'h1111);
    chk("port1_r2", 32'(o_rd[1]), 32'h2222);
    chk("port2_r1", 32'(o_rd[2]), 32'h1111);

    idle(1);
    issue(4'd4, 16'hA001);
    issue(4'd4, 16'hA002);
    issue(4'd4, 16'hA003);
    iv = 1; iw = 0; ren = 3'b001; ra[0] = 4'd4;
    ns = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!o_stall) break;
      ns++;
    end
    chk("b2b_stalls", ns, WIN);
    chk("b2b_data", 32'(o_rd[0]), 32'hA003);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 3) != 0);
      iw  = 1'($urandom);
      il  = ($urandom_range(0, 7) == 0);
      ia  = 4'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 9) == 0);
      ren = 3'($urandom);
      nd  = 16'($urandom);
      for (int p = 0; p < NR; p++)
        ra[p] = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        ra[0] = 4'd15;
      tick();
    end
    idle(5);

    $display("%0d/%0d checks passed",
             npass, ntot);
    $finish;
  end
endmodule
